zone_luma_accum: RTL and testbench

ZONE_LUMA_ACCUM -- requirements
Module: zone_luma_accum

---
 rtl/minitled_pkg.sv | 28 ++
 rtl/zone_luma_accum_if.sv | 25 ++
 rtl/zone_luma_accum_zone_locator.sv | 73 +++++++
 rtl/zone_luma_accum.sv | 157 +++++++++++++++
 tb/tb_zone_luma_accum.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minitled_pkg.sv
// Shared geometry defaults, FSM/mode encodings and index-width helper for the
// zone luma statistics blocks.
package minitled_pkg;

    localparam int DEF_ZONES_X = 24;
    localparam int DEF_ZONES_Y = 15;
    localparam int DEF_ZONE_W  = 46;
    localparam int DEF_ZONE_H  = 46;
    localparam int DEF_PITCH   = 53;
    localparam int DEF_X0      = 4;
    localparam int DEF_Y0      = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    typedef enum logic {
        MODE_SUM  = 1'b0,
        MODE_PEAK = 1'b1
    } luma_mode_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zone_luma_accum_if.sv
// Result stream of the zone accumulator: valid/ready handshake plus frame status.
interface zone_luma_accum_if
    import minitled_pkg::*;
#(
    parameter int IDX_W = idx_w(DEF_ZONES_X * DEF_ZONES_Y),
    parameter int OUT_W = 16
);
    logic             zone_valid;
    logic             zone_ready;
    logic [IDX_W-1:0] zone_index;
    logic [OUT_W-1:0] zone_value;
    logic             frame_done;
    logic             overflow;

    modport master (
        output zone_valid, zone_index, zone_value, frame_done, overflow,
        input  zone_ready
    );

    modport slave (
        input  zone_valid, zone_index, zone_value, frame_done, overflow,
        output zone_ready
    );

endinterface

// File: rtl/zone_luma_accum_zone_locator.sv
// Maps the raster position to a zone column inside the current band and flags
// band completion; bands advance by PITCH rows, columns use parallel comparators.
module zone_locator
    import minitled_pkg::*;
#(
    parameter int ZONES_X = DEF_ZONES_X,
    parameter int ZONES_Y = DEF_ZONES_Y,
    parameter int ZONE_W  = DEF_ZONE_W,
    parameter int ZONE_H  = DEF_ZONE_H,
    parameter int PITCH   = DEF_PITCH,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0,
    parameter int KW      = idx_w(ZONES_X)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          new_frame,
    input  logic          pix_valid,
    input  logic [10:0]   row_cnt,
    input  logic [10:0]   column_cnt,
    output logic          in_zone,
    output logic [KW-1:0] zone_col,
    output logic          band_done,
    output logic          last_band
);
    localparam int JW     = idx_w(ZONES_Y);
    localparam int LAST_X = X0 + (ZONES_X - 1) * PITCH + ZONE_W - 1;

    logic [JW-1:0] band_q;
    logic [11:0]   band_y_q;
    logic          frame_end_q;
    logic          row_hit, row_last, col_hit, col_last;

    always_comb begin
        col_hit  = 1'b0;
        zone_col = '0;
        for (int k = 0; k < ZONES_X; k++) begin
            if (int'(column_cnt) >= X0 + k * PITCH &&
                int'(column_cnt) <  X0 + k * PITCH + ZONE_W) begin
                col_hit  = 1'b1;
                zone_col = KW'(k);
            end
        end
        col_last  = (int'(column_cnt) == LAST_X);
        row_hit   = ({1'b0, row_cnt} >= band_y_q) &&
                    ({1'b0, row_cnt} <  band_y_q + 12'(ZONE_H));
        row_last  = ({1'b0, row_cnt} == band_y_q + 12'(ZONE_H - 1));
        // A coinciding frame start wins over the pixel; nothing counts after the last band.
        in_zone   = pix_valid && !new_frame && !frame_end_q && row_hit && col_hit;
        band_done = in_zone && row_last && col_last;
        last_band = (band_q == JW'(ZONES_Y - 1));
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            band_q      <= '0;
            band_y_q    <= 12'(Y0);
            frame_end_q <= 1'b0;
        end else if (new_frame) begin
            band_q      <= '0;
            band_y_q    <= 12'(Y0);
            frame_end_q <= 1'b0;
        end else if (band_done) begin
            if (last_band) begin
                frame_end_q <= 1'b1;
            end else begin
                band_q   <= band_q + 1'b1;
                band_y_q <= band_y_q + 12'(PITCH);
            end
        end
    end

endmodule

// File: rtl/zone_luma_accum.sv
// Per-zone luma sum/peak accumulator with ping-pong banks; each completed band
// is drained one zone per accepted transfer on the result stream.
module zone_luma_accum
    import minitled_pkg::*;
#(
    parameter int ZONES_X = DEF_ZONES_X,
    parameter int ZONES_Y = DEF_ZONES_Y,
    parameter int ZONE_W  = DEF_ZONE_W,
    parameter int ZONE_H  = DEF_ZONE_H,
    parameter int PITCH   = DEF_PITCH,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0,
    parameter int PIX_W   = 8,
    parameter int ACC_W   = 19,
    parameter int OUT_W   = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               new_frame,
    input  logic               mode,
    input  logic               pix_valid,
    input  logic [10:0]        row_cnt,
    input  logic [10:0]        column_cnt,
    input  logic [PIX_W-1:0]   pix,
    zone_luma_accum_if.master  zout
);
    localparam int IDX_W = idx_w(ZONES_X * ZONES_Y);
    localparam int KW    = idx_w(ZONES_X);

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PIX_W-1:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + (ACC_W + 1)'(p);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] peak_of(input logic [ACC_W-1:0] acc,
                                                 input logic [PIX_W-1:0] p);
        return ((ACC_W + 1)'(p) > {1'b0, acc}) ? ACC_W'(p) : acc;
    endfunction

    function automatic logic [OUT_W-1:0] result_of(input logic [ACC_W-1:0] acc,
                                                   input luma_mode_t m);
        if (m == MODE_PEAK) return acc[OUT_W-1:0];
        return acc[ACC_W-1 -: OUT_W];
    endfunction

    drain_state_t     state_q, state_d;
    luma_mode_t       mode_q;
    logic [ACC_W-1:0] bank_q [2][ZONES_X];
    logic             acc_sel_q, drain_sel_q, drain_last_q;
    logic [KW-1:0]    drain_k_q;
    logic [IDX_W-1:0] drain_idx_q, band_base_q;
    logic             overflow_q, frame_done_q;

    logic             in_zone, band_done, last_band;
    logic [KW-1:0]    zone_col;
    logic             xfer, last_xfer, start_drain, drop_band;
    logic [ACC_W-1:0] acc_cur, acc_next;

    zone_locator #(
        .ZONES_X(ZONES_X), .ZONES_Y(ZONES_Y), .ZONE_W(ZONE_W), .ZONE_H(ZONE_H),
        .PITCH(PITCH), .X0(X0), .Y0(Y0), .KW(KW)
    ) u_locator (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .new_frame  (new_frame),
        .pix_valid  (pix_valid),
        .row_cnt    (row_cnt),
        .column_cnt (column_cnt),
        .in_zone    (in_zone),
        .zone_col   (zone_col),
        .band_done  (band_done),
        .last_band  (last_band)
    );

    assign xfer        = (state_q == DRAIN) && zout.zone_ready;
    assign last_xfer   = xfer && (drain_k_q == KW'(ZONES_X - 1));
    // A drain finishing on the same edge frees its bank for the next band.
    assign start_drain = band_done && ((state_q == IDLE) || last_xfer);
    assign drop_band   = band_done && !start_drain;
    assign acc_cur     = bank_q[acc_sel_q][zone_col];
    assign acc_next    = (mode_q == MODE_PEAK) ? peak_of(acc_cur, pix) : sat_add(acc_cur, pix);

    always_comb begin
        state_d = state_q;
        if (new_frame)        state_d = IDLE;
        else if (start_drain) state_d = DRAIN;
        else if (last_xfer)   state_d = IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mode_q       <= MODE_SUM;
            acc_sel_q    <= 1'b0;
            drain_sel_q  <= 1'b0;
            drain_last_q <= 1'b0;
            drain_k_q    <= '0;
            drain_idx_q  <= '0;
            band_base_q  <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (new_frame) begin
            mode_q       <= luma_mode_t'(mode);
            acc_sel_q    <= 1'b0;
            drain_k_q    <= '0;
            drain_idx_q  <= '0;
            band_base_q  <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_xfer && drain_last_q;
            if (xfer) begin
                drain_k_q   <= drain_k_q + 1'b1;
                drain_idx_q <= drain_idx_q + 1'b1;
            end
            if (start_drain) begin
                drain_sel_q  <= acc_sel_q;
                acc_sel_q    <= ~acc_sel_q;
                drain_k_q    <= '0;
                drain_idx_q  <= band_base_q;
                drain_last_q <= last_band;
            end
            if (drop_band) overflow_q  <= 1'b1;
            if (band_done) band_base_q <= band_base_q + IDX_W'(ZONES_X);
        end
    end

    // Bank storage: accumulate into acc_sel, clear dropped bands and fully drained banks.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < ZONES_X; k++) bank_q[b][k] <= '0;
        end else if (new_frame) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < ZONES_X; k++) bank_q[b][k] <= '0;
        end else begin
            if (in_zone) bank_q[acc_sel_q][zone_col] <= acc_next;
            if (drop_band)
                for (int k = 0; k < ZONES_X; k++) bank_q[acc_sel_q][k] <= '0;
            if (last_xfer)
                for (int k = 0; k < ZONES_X; k++) bank_q[drain_sel_q][k] <= '0;
        end
    end

    assign zout.zone_valid = (state_q == DRAIN);
    assign zout.zone_index = zout.zone_valid ? drain_idx_q : '0;
    assign zout.zone_value = zout.zone_valid ? result_of(bank_q[drain_sel_q][drain_k_q], mode_q) : '0;
    assign zout.frame_done = frame_done_q;
    assign zout.overflow   = overflow_q;

endmodule

// File: tb/tb_zone_luma_accum.sv
// Scenario bench for zone_luma_accum on a 2x2-zone, 8x8-pixel frame geometry.
module tb_zone_luma_accum;
    localparam int ZX = 2, ZY = 2, ZW = 2, ZH = 2, PT = 3, OX = 1, OY = 1;
    localparam int ROWS = 8, COLS = 8, NZ = ZX * ZY;
    localparam int RDY_HIGH = 0, RDY_LOW = 1, RDY_RAND = 2, RDY_MANUAL = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        new_frame = 1'b0, mode = 1'b0, pix_valid = 1'b0;
    logic [10:0] row_cnt = '0, column_cnt = '0;
    logic [7:0]  pix = '0;

    zone_luma_accum_if #(.IDX_W(2), .OUT_W(8)) bus ();

    zone_luma_accum #(
        .ZONES_X(ZX), .ZONES_Y(ZY), .ZONE_W(ZW), .ZONE_H(ZH), .PITCH(PT),
        .X0(OX), .Y0(OY), .PIX_W(8), .ACC_W(8), .OUT_W(8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .new_frame  (new_frame),
        .mode       (mode),
        .pix_valid  (pix_valid),
        .row_cnt    (row_cnt),
        .column_cnt (column_cnt),
        .pix        (pix),
        .zout       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int tests_run = 0, tests_failed = 0;
    int fd_cnt = 0;
    int got_idx[$], got_val[$];
    int rdy_mode = RDY_HIGH;
    int low_run = 0;
    logic [7:0] img [ROWS][COLS];

    always @(negedge sys_clk) begin
        if (bus.zone_valid && bus.zone_ready) begin
            got_idx.push_back(int'(bus.zone_index));
            got_val.push_back(int'(bus.zone_value));
        end
        if (bus.frame_done) fd_cnt++;
    end

    always @(posedge sys_clk) begin
        #1;
        if (rdy_mode == RDY_HIGH) bus.zone_ready = 1'b1;
        else if (rdy_mode == RDY_LOW) bus.zone_ready = 1'b0;
        else if (rdy_mode == RDY_RAND) begin
            bus.zone_ready = (low_run >= 2) || ($urandom_range(0, 3) != 0);
            low_run = bus.zone_ready ? 0 : low_run + 1;
        end
    end

    // Reference: every zone is a ZWxZH window of the frame; sum clips at 255, peak is the max.
    function automatic int expect_zone(input int z, input bit m);
        int j = z / ZX, k = z % ZX, acc = 0;
        for (int r = OY + j * PT; r < OY + j * PT + ZH; r++)
            for (int c = OX + k * PT; c < OX + k * PT + ZW; c++) begin
                if (m) acc = (int'(img[r][c]) > acc) ? int'(img[r][c]) : acc;
                else   acc = acc + int'(img[r][c]);
            end
        return (acc > 255) ? 255 : acc;
    endfunction

    task automatic fill_const(input int v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = 8'(v);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = 8'($urandom_range(0, 255));
    endtask

    // One frame: new_frame coincides with an in-zone pixel that must be ignored,
    // and the mode input flips right after it to prove it is held.
    task automatic drive_frame(input bit m, input int gap_max, input bit chk_lat);
        got_idx.delete(); got_val.delete(); fd_cnt = 0;
        @(posedge sys_clk); #1;
        new_frame = 1'b1; mode = m; pix_valid = 1'b1;
        row_cnt = 11'(OY); column_cnt = 11'(OX); pix = 8'd77;
        @(posedge sys_clk); #1;
        new_frame = 1'b0; mode = ~m;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
                    pix_valid = 1'b0;
                    @(posedge sys_clk); #1;
                end
                pix_valid = 1'b1; row_cnt = 11'(r); column_cnt = 11'(c); pix = img[r][c];
                if (chk_lat && r == OY + ZH - 1 && c == OX + (ZX - 1) * PT + ZW - 1) begin
                    @(negedge sys_clk);
                    tests_run++;
                    if (bus.zone_valid !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL latency_before: zone_valid=%b, expected 0", bus.zone_valid);
                    end
                    @(posedge sys_clk); #1;
                    pix_valid = 1'b0;
                    @(negedge sys_clk);
                    tests_run++;
                    if (bus.zone_valid !== 1'b1 || bus.zone_index !== 2'd0) begin
                        tests_failed++;
                        $display("FAIL latency_after: valid=%b index=%0d, expected valid=1 index=0",
                                 bus.zone_valid, bus.zone_index);
                    end
                end
                @(posedge sys_clk); #1;
            end
        pix_valid = 1'b0;
        for (int t = 0; t < 60 && fd_cnt == 0; t++) @(posedge sys_clk);
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        tests_run++;
        if ({bus.zone_valid, bus.zone_index, bus.zone_value, bus.frame_done, bus.overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b index=%0d value=%0d done=%b ovf=%b, expected all 0",
                     bus.zone_valid, bus.zone_index, bus.zone_value, bus.frame_done, bus.overflow);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        tests_run++;
        if (bus.zone_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: zone_valid=%b, expected 0", bus.zone_valid);
        end
    endtask

    task automatic test_sum_mode();
        rdy_mode = RDY_HIGH;
        fill_const(10);
        drive_frame(1'b0, 0, 1'b1);
        tests_run++;
        if (got_idx.size() != NZ) begin
            tests_failed++;
            $display("FAIL sum_count: got %0d results, expected %0d", got_idx.size(), NZ);
        end
        for (int z = 0; z < NZ && z < got_idx.size(); z++) begin
            tests_run++;
            if (got_idx[z] !== z || got_val[z] !== expect_zone(z, 1'b0)) begin
                tests_failed++;
                $display("FAIL sum_result[%0d]: got idx=%0d val=%0d, expected idx=%0d val=%0d",
                         z, got_idx[z], got_val[z], z, expect_zone(z, 1'b0));
            end
        end
        tests_run++;
        if (fd_cnt != 1 || bus.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL sum_done: frame_done count=%0d ovf=%b, expected 1 and 0", fd_cnt, bus.overflow);
        end
    endtask

    task automatic test_peak_mode();
        rdy_mode = RDY_HIGH;
        fill_const(5);
        img[OY][OX + PT] = 8'd200;
        drive_frame(1'b1, 1, 1'b0);
        tests_run++;
        if (got_idx.size() != NZ || fd_cnt != 1) begin
            tests_failed++;
            $display("FAIL peak_count: got %0d results, %0d frame_done, expected %0d and 1",
                     got_idx.size(), fd_cnt, NZ);
        end
        for (int z = 0; z < NZ && z < got_idx.size(); z++) begin
            tests_run++;
            if (got_idx[z] !== z || got_val[z] !== expect_zone(z, 1'b1)) begin
                tests_failed++;
                $display("FAIL peak_result[%0d]: got idx=%0d val=%0d, expected idx=%0d val=%0d",
                         z, got_idx[z], got_val[z], z, expect_zone(z, 1'b1));
            end
        end
    endtask

    task automatic test_saturation();
        rdy_mode = RDY_HIGH;
        fill_const(100);
        drive_frame(1'b0, 2, 1'b0);
        tests_run++;
        if (got_idx.size() != NZ) begin
            tests_failed++;
            $display("FAIL sat_count: got %0d results, expected %0d", got_idx.size(), NZ);
        end
        for (int z = 0; z < NZ && z < got_idx.size(); z++) begin
            tests_run++;
            if (got_val[z] !== 255 || got_idx[z] !== z) begin
                tests_failed++;
                $display("FAIL sat_result[%0d]: got idx=%0d val=%0d, expected idx=%0d val=255",
                         z, got_idx[z], got_val[z], z);
            end
        end
    endtask

    task automatic test_stall();
        int hold_idx, hold_val;
        fill_rand();
        rdy_mode = RDY_MANUAL;
        bus.zone_ready = 1'b0;
        fork
            drive_frame(1'b0, 0, 1'b0);
            begin
                for (int t = 0; t < 400 && bus.zone_valid !== 1'b1; t++) @(negedge sys_clk);
                tests_run++;
                if (bus.zone_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall_wait: zone_valid=%b, expected 1 before timeout", bus.zone_valid);
                end
                hold_idx = int'(bus.zone_index);
                hold_val = int'(bus.zone_value);
                for (int s = 0; s < 5; s++) begin
                    @(negedge sys_clk);
                    tests_run++;
                    if (bus.zone_valid !== 1'b1 || int'(bus.zone_index) !== hold_idx ||
                        int'(bus.zone_value) !== hold_val || hold_idx !== 0) begin
                        tests_failed++;
                        $display("FAIL stall_hold[%0d]: valid=%b idx=%0d val=%0d, expected 1 idx=0 val=%0d",
                                 s, bus.zone_valid, bus.zone_index, bus.zone_value, hold_val);
                    end
                end
                @(posedge sys_clk); #1;
                bus.zone_ready = 1'b1;
                rdy_mode = RDY_HIGH;
            end
        join
        tests_run++;
        if (got_idx.size() != NZ || fd_cnt != 1) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d results, %0d frame_done, expected %0d and 1",
                     got_idx.size(), fd_cnt, NZ);
        end
        for (int z = 0; z < NZ && z < got_idx.size(); z++) begin
            tests_run++;
            if (got_idx[z] !== z || got_val[z] !== expect_zone(z, 1'b0)) begin
                tests_failed++;
                $display("FAIL stall_result[%0d]: got idx=%0d val=%0d, expected idx=%0d val=%0d",
                         z, got_idx[z], got_val[z], z, expect_zone(z, 1'b0));
            end
        end
    endtask

    task automatic test_overflow();
        fill_rand();
        rdy_mode = RDY_LOW;
        drive_frame(1'b0, 0, 1'b0);
        tests_run++;
        if (bus.overflow !== 1'b1 || bus.zone_valid !== 1'b1 || bus.zone_index !== 2'd0) begin
            tests_failed++;
            $display("FAIL ovf_flag: ovf=%b valid=%b idx=%0d, expected 1 1 0",
                     bus.overflow, bus.zone_valid, bus.zone_index);
        end
        rdy_mode = RDY_HIGH;
        repeat (10) @(posedge sys_clk);
        #1;
        tests_run++;
        if (got_idx.size() != ZX || fd_cnt != 0 || bus.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_drain: got %0d results, %0d frame_done, ovf=%b, expected %0d, 0, 1",
                     got_idx.size(), fd_cnt, bus.overflow, ZX);
        end
        for (int z = 0; z < ZX && z < got_idx.size(); z++) begin
            tests_run++;
            if (got_idx[z] !== z || got_val[z] !== expect_zone(z, 1'b0)) begin
                tests_failed++;
                $display("FAIL ovf_result[%0d]: got idx=%0d val=%0d, expected idx=%0d val=%0d",
                         z, got_idx[z], got_val[z], z, expect_zone(z, 1'b0));
            end
        end
    endtask

    task automatic test_abort();
        bit m;
        fill_rand();
        rdy_mode = RDY_LOW;
        drive_frame(1'b0, 0, 1'b0);
        @(posedge sys_clk); #1;
        new_frame = 1'b1; pix_valid = 1'b0;
        @(posedge sys_clk); #1;
        new_frame = 1'b0;
        @(negedge sys_clk);
        tests_run++;
        if (bus.zone_valid !== 1'b0 || bus.overflow !== 1'b0 || got_idx.size() != 0) begin
            tests_failed++;
            $display("FAIL abort_drain: valid=%b ovf=%b transfers=%0d, expected 0 0 0",
                     bus.zone_valid, bus.overflow, got_idx.size());
        end
        rdy_mode = RDY_HIGH;
        fill_rand();
        m = 1'($urandom_range(0, 1));
        drive_frame(m, 1, 1'b0);
        tests_run++;
        if (got_idx.size() != NZ || fd_cnt != 1) begin
            tests_failed++;
            $display("FAIL abort_next_count: got %0d results, %0d frame_done, expected %0d and 1",
                     got_idx.size(), fd_cnt, NZ);
        end
        for (int z = 0; z < NZ && z < got_idx.size(); z++) begin
            tests_run++;
            if (got_idx[z] !== z || got_val[z] !== expect_zone(z, m)) begin
                tests_failed++;
                $display("FAIL abort_next[%0d]: got idx=%0d val=%0d, expected idx=%0d val=%0d",
                         z, got_idx[z], got_val[z], z, expect_zone(z, m));
            end
        end
    endtask

    task automatic test_random_frames();
        bit m;
        rdy_mode = RDY_RAND;
        for (int f = 0; f < 6; f++) begin
            fill_rand();
            m = 1'($urandom_range(0, 1));
            drive_frame(m, 2, 1'b0);
            tests_run++;
            if (got_idx.size() != NZ || fd_cnt != 1 || bus.overflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_frame%0d: got %0d results, %0d frame_done, ovf=%b, expected %0d, 1, 0",
                         f, got_idx.size(), fd_cnt, bus.overflow, NZ);
            end
            for (int z = 0; z < NZ && z < got_idx.size(); z++) begin
                tests_run++;
                if (got_idx[z] !== z || got_val[z] !== expect_zone(z, m)) begin
                    tests_failed++;
                    $display("FAIL rand_frame%0d[%0d]: got idx=%0d val=%0d, expected idx=%0d val=%0d",
                             f, z, got_idx[z], got_val[z], z, expect_zone(z, m));
                end
            end
        end
        rdy_mode = RDY_HIGH;
    endtask

    initial begin
        bus.zone_ready = 1'b0;
        #2 sys_rst = 1'b0;
        test_reset();
        test_sum_mode();
        test_peak_mode();
        test_saturation();
        test_stall();
        test_overflow();
        test_abort();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
